// File: rtl/alu_datapath_pkg.sv
// Shared constants and types for the accumulator/B-register ALU datapath.
package alu_datapath_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {NONE, ACC, BREG, ALU} bus_src_e;

  // ALU wins over Breg, Breg over Acc, when several OEs are asserted.
  function automatic bus_src_e bus_select(input logic oe_acc, input logic oe_breg,
                                          input logic oe_alu);
    if (oe_alu) return ALU;
    if (oe_breg) return BREG;
    if (oe_acc) return ACC;
    return NONE;
  endfunction

endpackage

// File: rtl/alu_datapath_if.sv
// Control/bus bundle for alu_datapath; carry/zero exist only when ALU_FLAGS_EN is defined.
interface alu_datapath_if
  import alu_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
);

   logic [WIDTH-1:0] Bus_in;
   logic [WIDTH-1:0] in;
   logic             WE_Acc;
   logic             load_Acc;
   logic             OE_Acc;
   logic             WE_Breg;
   logic             load_Breg;
   logic             OE_Breg;
   logic             OE_ALU;
   logic             SUB;
   logic [WIDTH-1:0] Acc_out;
   logic [WIDTH-1:0] Breg_out;
   logic [WIDTH-1:0] ALU_out;
   logic [WIDTH-1:0] Bus_out;
   logic             bus_drive;
   logic             bus_conflict;
`ifdef ALU_FLAGS_EN
   logic             carry;
   logic             zero;
`endif

   modport master (
      output Bus_in, in, WE_Acc, load_Acc, OE_Acc, WE_Breg, load_Breg, OE_Breg, OE_ALU, SUB,
      input  Acc_out, Breg_out, ALU_out, Bus_out, bus_drive, bus_conflict
`ifdef ALU_FLAGS_EN
      , input carry, zero
`endif
   );

   modport slave (
      input  Bus_in, in, WE_Acc, load_Acc, OE_Acc, WE_Breg, load_Breg, OE_Breg, OE_ALU, SUB,
      output Acc_out, Breg_out, ALU_out, Bus_out, bus_drive, bus_conflict
`ifdef ALU_FLAGS_EN
      , output carry, zero
`endif
   );

endinterface

// File: rtl/alu_datapath_addsub.sv
// Combinational WIDTH-bit adder/subtractor; on subtract, carry is the no-borrow flag.
module alu_datapath_addsub
  import alu_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;

   // a - b computed as a + ~b + 1 so the carry-out reads as "no borrow".
   assign b_eff = b ^ {WIDTH{sub}};
   assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   assign sum   = full[WIDTH-1:0];
   assign carry = full[WIDTH];

endmodule

// File: rtl/alu_datapath.sv
// Acc/B registers, registered ALU result and prioritised bus driver.
// Define ALU_FLAGS_EN to add registered carry/zero flags.
module alu_datapath
  import alu_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic          CLK,
   input  logic          RESET,
   alu_datapath_if.slave bus
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] breg_q, breg_d;
   logic [WIDTH-1:0] alu_q;
   logic [WIDTH-1:0] sum;
   bus_src_e         bus_src;

`ifdef ALU_FLAGS_EN
   logic carry_w;
   logic carry_q;
   logic zero_q;
`else
   logic carry_unused;
`endif

   alu_datapath_addsub #(
      .WIDTH(WIDTH)
   ) u_addsub (
      .a    (acc_q),
      .b    (breg_q),
      .sub  (bus.SUB),
`ifdef ALU_FLAGS_EN
      .carry(carry_w),
`else
      .carry(carry_unused),
`endif
      .sum  (sum)
   );

   // Bus write has priority over programmer load.
   always_comb begin
      acc_d = acc_q;
      if (bus.WE_Acc) acc_d = bus.Bus_in;
      else if (bus.load_Acc) acc_d = bus.in;

      breg_d = breg_q;
      if (bus.WE_Breg) breg_d = bus.Bus_in;
      else if (bus.load_Breg) breg_d = bus.in;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         acc_q  <= '0;
         breg_q <= '0;
         alu_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         breg_q <= breg_d;
         alu_q  <= sum;
      end
   end

`ifdef ALU_FLAGS_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         carry_q <= carry_w;
         zero_q  <= (sum == '0);
      end
   end

   assign bus.carry = carry_q;
   assign bus.zero  = zero_q;
`endif

   assign bus_src = bus_select(bus.OE_Acc, bus.OE_Breg, bus.OE_ALU);

   always_comb begin
      bus.Bus_out = '0;
      case (bus_src)
         ALU:     bus.Bus_out = alu_q;
         BREG:    bus.Bus_out = breg_q;
         ACC:     bus.Bus_out = acc_q;
         default: bus.Bus_out = '0;
      endcase
   end

   assign bus.bus_drive    = bus.OE_Acc | bus.OE_Breg | bus.OE_ALU;
   assign bus.bus_conflict = (bus.OE_Acc & bus.OE_Breg) | (bus.OE_Acc & bus.OE_ALU) |
                             (bus.OE_Breg & bus.OE_ALU);

   assign bus.Acc_out  = acc_q;
   assign bus.Breg_out = breg_q;
   assign bus.ALU_out  = alu_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed scoreboard bench for alu_datapath; flag checks follow ALU_FLAGS_EN.
module tb_alu_datapath;

   localparam int W = 8;

   typedef struct {
      string        tag;
      int           sel;
      logic [W-1:0] exp;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   logic [W-1:0] m_acc, m_b, m_alu;
   logic         m_carry, m_zero;

   always #5 CLK = ~CLK;

   alu_datapath_if #(.WIDTH(W)) bus ();

   alu_datapath #(
      .WIDTH(W)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
   );

   function automatic logic [W-1:0] observe(input int sel);
      case (sel)
         0:       return bus.Acc_out;
         1:       return bus.Breg_out;
         2:       return bus.ALU_out;
         3:       return bus.Bus_out;
         4:       return {{(W-1){1'b0}}, bus.bus_drive};
         5:       return {{(W-1){1'b0}}, bus.bus_conflict};
`ifdef ALU_FLAGS_EN
         6:       return {{(W-1){1'b0}}, bus.carry};
         7:       return {{(W-1){1'b0}}, bus.zero};
`endif
         default: return 'x;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input logic [W-1:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t         e;
      logic [W-1:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         n_vec++;
         assert (obs === e.exp)
         else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic expect_regs(input string tag);
      expect_val({tag, ".acc"}, 0, m_acc);
      expect_val({tag, ".breg"}, 1, m_b);
      expect_val({tag, ".alu"}, 2, m_alu);
`ifdef ALU_FLAGS_EN
      expect_val({tag, ".carry"}, 6, {{(W-1){1'b0}}, m_carry});
      expect_val({tag, ".zero"}, 7, {{(W-1){1'b0}}, m_zero});
`endif
   endtask

   task automatic idle();
      bus.WE_Acc    = 1'b0;
      bus.load_Acc  = 1'b0;
      bus.OE_Acc    = 1'b0;
      bus.WE_Breg   = 1'b0;
      bus.load_Breg = 1'b0;
      bus.OE_Breg   = 1'b0;
      bus.OE_ALU    = 1'b0;
   endtask

   // Update the model from the inputs currently driven, then take one clock edge.
   task automatic clock_step();
      logic [W:0] wide;
      if (bus.SUB) begin
         m_alu   = m_acc - m_b;
         m_carry = (m_acc >= m_b);
      end else begin
         wide    = {1'b0, m_acc} + {1'b0, m_b};
         m_alu   = wide[W-1:0];
         m_carry = wide[W];
      end
      m_zero = (m_alu == '0);
      if (bus.WE_Acc) m_acc = bus.Bus_in;
      else if (bus.load_Acc) m_acc = bus.in;
      if (bus.WE_Breg) m_b = bus.Bus_in;
      else if (bus.load_Breg) m_b = bus.in;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic model_reset();
      m_acc   = '0;
      m_b     = '0;
      m_alu   = '0;
      m_carry = 1'b0;
      m_zero  = 1'b0;
   endtask

   initial begin
      RESET      = 1'b1;
      bus.Bus_in = '0;
      bus.in     = '0;
      bus.SUB    = 1'b0;
      idle();
      model_reset();
      #1;
      expect_regs("reset");
      expect_val("reset.bus_out", 3, 8'h00);
      expect_val("reset.drive", 4, 8'h00);
      drain();
      @(negedge CLK);
      RESET = 1'b0;

      // 5 + 3 and 5 - 3
      idle(); bus.in = 8'h05; bus.load_Acc = 1'b1;
      clock_step(); expect_regs("ld_acc5"); drain();
      idle(); bus.in = 8'h03; bus.load_Breg = 1'b1; bus.SUB = 1'b0;
      clock_step(); expect_regs("ld_b3"); drain();
      idle();
      clock_step(); expect_val("add_5_3", 2, 8'h08); expect_regs("add"); drain();
      bus.SUB = 1'b1;
      clock_step(); expect_val("sub_5_3", 2, 8'h02); expect_regs("sub"); drain();

      // 3 - 5 wraps with borrow
      idle(); bus.in = 8'h03; bus.load_Acc = 1'b1;
      clock_step();
      idle(); bus.in = 8'h05; bus.load_Breg = 1'b1;
      clock_step();
      idle();
      clock_step(); expect_val("sub_3_5", 2, 8'hFE); expect_regs("sub_3_5");
`ifdef ALU_FLAGS_EN
      expect_val("sub_3_5.carry", 6, 8'h00);
`endif
      drain();

      // FF + 01 overflows to zero
      idle(); bus.in = 8'hFF; bus.load_Acc = 1'b1;
      clock_step();
      idle(); bus.in = 8'h01; bus.load_Breg = 1'b1; bus.SUB = 1'b0;
      clock_step();
      idle();
      clock_step(); expect_val("add_ff_1", 2, 8'h00); expect_regs("add_ff_1");
`ifdef ALU_FLAGS_EN
      expect_val("add_ff_1.carry", 6, 8'h01);
      expect_val("add_ff_1.zero", 7, 8'h01);
`endif
      drain();

      // WE beats load; both WEs take the same bus value
      idle(); bus.Bus_in = 8'hAA; bus.in = 8'h55;
      bus.WE_Acc = 1'b1; bus.load_Acc = 1'b1; bus.WE_Breg = 1'b1;
      clock_step(); expect_val("we_prio.acc", 0, 8'hAA); expect_val("we_both.b", 1, 8'hAA);
      expect_regs("we_prio"); drain();
      idle();
      clock_step(); expect_val("add_aa_aa", 2, 8'h54); expect_regs("add_aa"); drain();

      // Bus mux and flags, combinational
      idle(); bus.in = 8'h11; bus.load_Acc = 1'b1;
      clock_step(); drain();
      idle(); bus.OE_Acc = 1'b1; bus.OE_ALU = 1'b1; #1;
      expect_val("oe_acc_alu.bus", 3, m_alu); expect_val("oe_acc_alu.conf", 5, 8'h01);
      expect_val("oe_acc_alu.drive", 4, 8'h01); drain();
      idle(); bus.OE_Breg = 1'b1; #1;
      expect_val("oe_b.bus", 3, m_b); expect_val("oe_b.conf", 5, 8'h00); drain();
      idle(); bus.OE_Acc = 1'b1; bus.OE_Breg = 1'b1; #1;
      expect_val("oe_acc_b.bus", 3, m_b); expect_val("oe_acc_b.conf", 5, 8'h01); drain();
      idle(); bus.OE_Acc = 1'b1; #1;
      expect_val("oe_acc.bus", 3, m_acc); expect_val("oe_acc.conf", 5, 8'h00); drain();
      idle(); #1;
      expect_val("no_oe.bus", 3, 8'h00); expect_val("no_oe.drive", 4, 8'h00);
      expect_val("no_oe.conf", 5, 8'h00); drain();

      // OEs do not disturb registers; a driving register still captures Bus_in
      idle(); bus.OE_Acc = 1'b1; bus.OE_Breg = 1'b1; bus.OE_ALU = 1'b1; bus.SUB = 1'b1;
      clock_step(); expect_regs("oe_hold"); drain();
      idle(); bus.OE_Acc = 1'b1; bus.WE_Acc = 1'b1; bus.Bus_in = 8'h3C;
      clock_step(); expect_val("oe_we.acc", 0, 8'h3C); expect_regs("oe_we"); drain();

      // Mid-cycle asynchronous reset
      idle(); bus.in = 8'h77; bus.load_Breg = 1'b1;
      @(posedge CLK); #2;
      RESET = 1'b1; #1;
      model_reset();
      expect_regs("async_rst"); drain();
      RESET = 1'b0;
      @(negedge CLK);
      idle(); bus.in = 8'h09; bus.load_Acc = 1'b1; bus.SUB = 1'b0;
      clock_step(); expect_val("post_rst.acc", 0, 8'h09); expect_regs("post_rst"); drain();
      idle();
      clock_step(); expect_val("post_rst.alu", 2, 8'h09); drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of all registers, ALU and bus.
REQ-002 The block SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port Bus_in, input, WIDTH, data currently on the system bus.
REQ-005 The block SHALL have port in, input, WIDTH, programmer switch data.
REQ-006 The block SHALL have ports WE_Acc, load_Acc and OE_Acc, each input, 1: Acc write-from-bus, load-from-programmer and drive-bus.
REQ-007 The block SHALL have ports WE_Breg, load_Breg and OE_Breg, each input, 1: B-register write-from-bus, load-from-programmer and drive-bus.
REQ-008 The block SHALL have ports OE_ALU (input, 1, ALU drives bus) and SUB (input, 1, 1 = subtract, 0 = add).
REQ-009 The block SHALL have ports Acc_out, Breg_out and ALU_out, each output, WIDTH: register contents.
REQ-010 The block SHALL have ports Bus_out (output, WIDTH, data driven to bus) and bus_drive (output, 1, any OE active).
REQ-011 The block SHALL have port bus_conflict, output, 1, more than one OE asserted.

Function
REQ-012 On each CLK edge the Acc SHALL load Bus_in if WE_Acc=1; else load in if load_Acc=1; else hold (WE has priority over load).
REQ-013 The B register SHALL follow the same rule as REQ-012 using WE_Breg, load_Breg and Bus_in/in.
REQ-014 The ALU result SHALL be Acc_out+Breg_out when SUB=0 and Acc_out-Breg_out (two's complement) when SUB=1, truncated modulo 2^WIDTH.
REQ-015 ALU_out SHALL be a register updated every CLK edge from the pre-edge Acc_out, Breg_out and SUB, giving latency 1 cycle after the operand registers change.
REQ-016 Bus_out SHALL be combinational with priority ALU > Breg > Acc among asserted OEs, and SHALL be 0 when no OE is asserted.
REQ-017 bus_drive SHALL equal OE_Acc|OE_Breg|OE_ALU, and bus_conflict SHALL be 1 whenever two or more OEs are asserted, both combinational.
REQ-018 Simultaneous WE to Acc and B SHALL load both from the same Bus_in; a register driving the bus while written SHALL capture Bus_in (bus loopback is external).
REQ-019 OE inputs SHALL have no effect on register contents.

Reset
REQ-020 When RESET=1, Acc_out, Breg_out, ALU_out (and the flags of REQ-022) SHALL go to 0 immediately, independent of CLK.
REQ-021 RESET SHALL override WE and load, and the first edge after RESET deasserts SHALL obey REQ-012 to REQ-015 normally.

Configuration
REQ-022 With macro ALU_FLAGS_EN defined, outputs carry and zero (1 bit each) SHALL exist and be registered with ALU_out: carry = bit WIDTH of the add on SUB=0, and carry = no-borrow (Acc>=B unsigned) on SUB=1; zero = (result==0).
REQ-023 Without ALU_FLAGS_EN, the carry and zero ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Package alu_datapath_pkg SHALL hold the default WIDTH constant and the bus-source enum (NONE, ACC, BREG, ALU).
REQ-025 The adder/subtractor SHALL be sub-module alu_datapath_addsub (combinational, WIDTH-parameterised, producing sum and carry-out), and the registers and bus mux SHALL live in alu_datapath.

Verification
REQ-026 The bench SHALL cover: RESET pulse mid-cycle -> Acc_out, Breg_out, ALU_out = 0 without waiting for a clock edge.
REQ-027 The bench SHALL cover: load_Acc=1 with in=0x05, then load_Breg=1 with in=0x03, SUB=0 -> one edge later ALU_out=0x08; with SUB=1 -> ALU_out=0x02.
REQ-028 The bench SHALL cover: Acc=0x03, B=0x05, SUB=1 -> ALU_out=0xFE (carry=0); Acc=0xFF, B=0x01, SUB=0 -> ALU_out=0x00 (carry=1, zero=1).
REQ-029 The bench SHALL cover: WE_Acc=1 and load_Acc=1 together, Bus_in=0xAA, in=0x55 -> Acc_out=0xAA.
REQ-030 The bench SHALL cover: OE_Acc=1 and OE_ALU=1 -> Bus_out=ALU_out, bus_conflict=1; no OE -> Bus_out=0x00, bus_drive=0.
